quad_encoder: RTL and testbench

Parametrised quadrature-encoder front end: the successor of the single-channel `Encoder` edge counter. It conditions the A, B and Z (index) pins with a synchroniser and glitch filter, decodes quadrature in X1/X2/X4 modes, and keeps a signed-wrap up/down position count. It also reports direction, a sticky illegal-transition error and index events. It sits between the board encoder pins and the position/velocity consumers.

---
 rtl/quad_enc_pkg.sv | 26 ++
 rtl/quad_enc_filter.sv | 56 +++++
 rtl/quad_encoder.sv | 104 ++++++++++
 tb/tb_quad_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/quad_enc_pkg.sv
// Shared constants for the quadrature encoder front end: decode modes and
// the forward (A leads B) Gray sequence.
package quad_enc_pkg;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    // Forward sequence as {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] AB_S0 = 2'b00;
    localparam logic [1:0] AB_S1 = 2'b10;
    localparam logic [1:0] AB_S2 = 2'b11;
    localparam logic [1:0] AB_S3 = 2'b01;

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            AB_S0:   nxt = AB_S1;
            AB_S1:   nxt = AB_S2;
            AB_S2:   nxt = AB_S3;
            default: nxt = AB_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_enc_filter.sv
// Two-flop synchroniser followed by a FILT-cycle stability filter for one
// asynchronous encoder pin. FILT = 0 passes the synchronised level straight through.
module quad_enc_filter
    import quad_enc_pkg::*;
#(
    parameter int FILT = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_pin,
    output logic o_filt
);

    logic r_sync1;
    logic r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (FILT == 0) begin : g_bypass
            assign o_filt = r_sync2;
        end else begin : g_filter
            localparam logic [3:0] L_LAST = 4'(FILT - 1);
            logic       r_out;
            logic [3:0] r_cnt;

            // Any return to the current output level restarts the stability count.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_out <= 1'b0;
                    r_cnt <= 4'd0;
                end else if (r_sync2 == r_out) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == L_LAST) begin
                    r_out <= r_sync2;
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            assign o_filt = r_out;
        end
    endgenerate

endmodule

// File: rtl/quad_encoder.sv
// Quadrature encoder front end: conditions A/B/Z, decodes X1/X2/X4 steps and
// keeps a wrapping position count with direction, sticky error and index pulse.
module quad_encoder
    import quad_enc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FILT  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             A,
    input  logic             B,
    input  logic             Z,
    input  logic [1:0]       MODE,
    input  logic             IDX_EN,
    input  logic             CLR,
    output logic [WIDTH-1:0] Count,
    output logic             DIR,
    output logic             ERR,
    output logic             IDX
);

    logic       w_fa;
    logic       w_fb;
    logic       w_fz;
    logic [1:0] w_ab;
    logic [1:0] w_diff;
    logic       w_step;
    logic       w_up;
    logic       w_illegal;
    logic       w_z_rise;
    logic       w_idx_clr;

    logic [1:0] r_prev_ab;
    logic       r_prev_z;

    quad_enc_filter #(.FILT(FILT)) u_filt_a (.CLK(CLK), .RST_N(RST_N), .i_pin(A), .o_filt(w_fa));
    quad_enc_filter #(.FILT(FILT)) u_filt_b (.CLK(CLK), .RST_N(RST_N), .i_pin(B), .o_filt(w_fb));
    quad_enc_filter #(.FILT(FILT)) u_filt_z (.CLK(CLK), .RST_N(RST_N), .i_pin(Z), .o_filt(w_fz));

    assign w_ab      = {w_fa, w_fb};
    assign w_diff    = w_ab ^ r_prev_ab;
    assign w_illegal = (w_diff == 2'b11);
    assign w_z_rise  = w_fz & ~r_prev_z;
    assign w_idx_clr = IDX_EN & w_z_rise;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_step = 1'b0;
        w_up   = 1'b0;
        case (MODE)
            MODE_X1: begin
                if (w_diff == 2'b10 && w_ab[1]) begin
                    w_step = 1'b1;
                    w_up   = ~w_ab[0];
                end
            end
            MODE_X2: begin
                // Forward on an A edge exactly when the new A differs from B.
                if (w_diff == 2'b10) begin
                    w_step = 1'b1;
                    w_up   = w_ab[1] ^ w_ab[0];
                end
            end
            default: begin
                if (w_diff == 2'b10 || w_diff == 2'b01) begin
                    w_step = 1'b1;
                    w_up   = (w_ab == fwd_next(r_prev_ab));
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prev_ab <= 2'b00;
            r_prev_z  <= 1'b0;
            Count     <= '0;
            DIR       <= 1'b1;
            ERR       <= 1'b0;
            IDX       <= 1'b0;
        end else begin
            r_prev_ab <= w_ab;
            r_prev_z  <= w_fz;
            IDX       <= w_z_rise;
            // Clears outrank a step; a step coinciding with a clear is dropped.
            if (CLR) begin
                Count <= '0;
                ERR   <= 1'b0;
            end else begin
                if (w_illegal) begin
                    ERR <= 1'b1;
                end
                if (w_idx_clr) begin
                    Count <= '0;
                end else if (w_step) begin
                    Count <= w_up ? Count + WIDTH'(1) : Count - WIDTH'(1);
                    DIR   <= w_up;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder.sv
// Directed bench for quad_encoder (WIDTH=8, FILT=4): mode decode, wrap,
// glitch filtering, illegal transitions, CLR, index handling and async reset.
module tb_quad_encoder;

    localparam int WIDTH = 8;
    localparam int FILT  = 4;
    localparam int HOLD  = 12;

    logic             clk;
    logic             rst_n;
    logic             a;
    logic             b;
    logic             z;
    logic [1:0]       mode;
    logic             idx_en;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             err;
    logic             idx;

    int n_assert;
    int n_fail;
    int idx_pulses;
    int idx_before;

    quad_encoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .A      (a),
        .B      (b),
        .Z      (z),
        .MODE   (mode),
        .IDX_EN (idx_en),
        .CLR    (clr),
        .Count  (count),
        .DIR    (dir),
        .ERR    (err),
        .IDX    (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (idx === 1'b1) idx_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive_ab(input logic [1:0] v);
        @(negedge clk);
        a = v[1];
        b = v[0];
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic fwd_steps(input int n);
        for (int i = 0; i < n; i++) drive_ab(fwd({a, b}));
    endtask

    task automatic rev_steps(input int n);
        for (int i = 0; i < n; i++) drive_ab(rev({a, b}));
    endtask

    task automatic pulse_a(input int cycles);
        @(negedge clk);
        a = 1'b1;
        repeat (cycles) @(negedge clk);
        a = 1'b0;
        repeat (2 * HOLD) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_z();
        @(negedge clk);
        z = 1'b1;
        repeat (HOLD) @(negedge clk);
        z = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        idx_pulses = 0;
        rst_n  = 1'b0;
        a      = 1'b0;
        b      = 1'b0;
        z      = 1'b0;
        mode   = 2'b10;
        idx_en = 1'b0;
        clr    = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_count", 32'(count), 32'd0);
        check("reset_dir",   32'(dir),   32'd1);
        check("reset_err",   32'(err),   32'd0);
        check("reset_idx",   32'(idx),   32'd0);
        rst_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        check("idle_count", 32'(count), 32'd0);

        // X4 forward, 4 full cycles
        fwd_steps(1);
        check("x4_first_step", 32'(count), 32'd1);
        fwd_steps(15);
        check("x4_fwd_count", 32'(count), 32'd16);
        check("x4_fwd_dir",   32'(dir),   32'd1);
        check("x4_fwd_err",   32'(err),   32'd0);

        // Wrap below zero and back
        pulse_clr();
        check("clr_count", 32'(count), 32'd0);
        rev_steps(1);
        check("x4_wrap_down",     32'(count), 32'd255);
        check("x4_wrap_down_dir", 32'(dir),   32'd0);
        fwd_steps(1);
        check("x4_wrap_up",     32'(count), 32'd0);
        check("x4_wrap_up_dir", 32'(dir),   32'd1);

        // X1 forward then X2 reverse
        mode = 2'b00;
        fwd_steps(16);
        check("x1_fwd_count", 32'(count), 32'd4);
        mode = 2'b01;
        rev_steps(8);
        check("x2_rev_count", 32'(count), 32'd0);
        check("x2_rev_dir",   32'(dir),   32'd0);

        // Glitch filtering
        mode = 2'b10;
        pulse_a(3);
        check("glitch3_count", 32'(count), 32'd0);
        check("glitch3_dir",   32'(dir),   32'd0);
        mode = 2'b00;
        pulse_a(5);
        check("glitch5_count", 32'(count), 32'd1);
        check("glitch5_dir",   32'(dir),   32'd1);

        // Illegal transitions, then CLR
        mode = 2'b11;
        drive_ab(2'b11);
        check("illegal_err",   32'(err),   32'd1);
        check("illegal_count", 32'(count), 32'd1);
        drive_ab(2'b00);
        check("illegal_back_err",   32'(err),   32'd1);
        check("illegal_back_count", 32'(count), 32'd1);
        pulse_clr();
        check("clr_err",       32'(err),   32'd0);
        check("clr_err_count", 32'(count), 32'd0);

        // Index with clear enabled
        fwd_steps(37);
        check("pre_idx_count", 32'(count), 32'd37);
        idx_en     = 1'b1;
        idx_before = idx_pulses;
        pulse_z();
        check("idx_en_pulses", 32'(idx_pulses - idx_before), 32'd1);
        check("idx_en_count",  32'(count), 32'd0);

        // Index with clear disabled
        idx_en = 1'b0;
        fwd_steps(37);
        idx_before = idx_pulses;
        pulse_z();
        check("idx_dis_pulses", 32'(idx_pulses - idx_before), 32'd1);
        check("idx_dis_count",  32'(count), 32'd37);

        // Asynchronous reset mid-rotation
        rev_steps(1);
        check("pre_rst_count", 32'(count), 32'd36);
        check("pre_rst_dir",   32'(dir),   32'd0);
        @(negedge clk);
        {a, b} = rev({a, b});
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_dir",   32'(dir),   32'd1);
        check("async_rst_err",   32'(err),   32'd0);
        check("async_rst_idx",   32'(idx),   32'd0);
        repeat (3) @(negedge clk);
        check("held_rst_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
